axis_frame_averager: RTL and testbench
======================================

# axis_frame_averager

Parametrised successor to the complex block averager in the processing chain. It accumulates per-bin complex samples (imag in the upper half, real in the lower half) over repeated frames in an internal memory. It supports two modes:
- block averaging over 2^log_count frames;
- continuous exponential averaging.

It uses full AXI4-Stream handshaking, so M_AXIS_tvalid never waits on M_AXIS_tready. Frame length is runtime-selectable up to the memory depth.

## Interface
- DATA_WIDTH, 16: width of one real/imag component; tdata is 2*DATA_WIDTH.
- MAX_LOG_LENGTH, 10: memory depth is 2^MAX_LOG_LENGTH bins.
- MAX_LOG_COUNT, 8: largest legal log_count.
- ACC_WIDTH, DATA_WIDTH+MAX_LOG_COUNT: width of one accumulator component.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- clear  in  1  synchronous soft restart; latches configuration
- mode  in  1  0 = block average, 1 = exponential average
- log_length  in  $clog2(MAX_LOG_LENGTH+1)  frame length L = 2^log_length
- log_count  in  $clog2(MAX_LOG_COUNT+1)  N = 2^log_count frames (mode 0) or shift k (mode 1)
- S_AXIS_tdata  in  2*DATA_WIDTH  {imag, real}, two's complement
- S_AXIS_tvalid / S_AXIS_tready / S_AXIS_tlast  in / out / in  input stream
- M_AXIS_tdata  out  2*DATA_WIDTH  averaged {imag, real}
- M_AXIS_tvalid / M_AXIS_tready / M_AXIS_tlast  out / in / out  output stream
- sync_error  out  1  sticky flag: S_AXIS_tlast disagreed with bin position

## Operation

**Configuration**
- mode, log_length and log_count are captured into shadow registers on reset release and on clear; they are ignored otherwise.
- log_length is clamped to the range 1..MAX_LOG_LENGTH.
- log_count is clamped to MAX_LOG_COUNT.

**Counters**
- bin counts 0..L-1 and wraps.
- frame counts 0..N-1; it increments when bin L-1 is accepted.

**Memory**
- Internal, inferred simple dual-port, 2*ACC_WIDTH wide, read-first, 1-cycle read latency, contents not reset.
- Read address is the bin of the accepted beat; write-back happens one stage later.

**Arithmetic**
- s is the sample sign-extended to ACC_WIDTH; a is the stored accumulator. Both components are processed independently.
- Mode 0, frame 0: write s.
- Mode 0, frames 1..N-2: write a+s.
- Mode 0, frame N-1: output (a+s)>>>log_count. Write-back is don't-care.
- Mode 0 with N=1: every frame outputs s unchanged.
- Mode 1, first frame after reset/clear: write s<<k and output s.
- Mode 1, later frames: a' = a - (a>>>k) + s; write a' and output a'>>>k every frame.
- All shifts are arithmetic (floor). The result is truncated to DATA_WIDTH; the range is provably preserved, so no saturation logic is needed.

**Output framing**
- M_AXIS_tlast = 1 on the output beat of bin L-1.
- Beats are emitted only in frames that produce output. Non-output frames are absorbed: input is accepted and nothing is emitted.

**Frame check**
- If S_AXIS_tlast is accepted with bin ≠ L-1, or bin L-1 is accepted without tlast, sync_error is set.
- sync_error is cleared only by reset or clear.
- Counters are not resynchronised by S_AXIS_tlast.

## Timing

**Handshake and pipeline**
- adv = !M_AXIS_tvalid || M_AXIS_tready; S_AXIS_tready = adv. S_AXIS_tready is combinational from M_AXIS_tready and registered state only.
- Two stages: accept/read, then compute/write/output register.
- Stage 1 advances only on adv. The memory read enable is the accept strobe, so read data holds during a stall.
- Latency: a beat accepted at edge t appears on M_AXIS at edge t+1, i.e. M_AXIS_tvalid is high in the cycle after t+1.
- Throughput is 1 beat/cycle when M_AXIS_tready=1.

**AXI-stream rules**
- M_AXIS_tdata and M_AXIS_tlast are stable while tvalid=1 and tready=0.
- M_AXIS_tvalid falls only after a handshake with no new output beat loaded.

**Hazard**
- With L≥2, the next read of a bin occurs at least one edge after its write-back, so no forwarding is required. L=1 is excluded by the clamp.

**Reset / clear**
- All outputs are 0 at reset: S_AXIS_tready is 0 during reset and 1 after; M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, sync_error=0.
- bin=0, frame=0, the mode-1 init flag is set, and the pipeline is flushed.
- clear behaves identically to reset but takes one cycle. An in-flight output beat is dropped, so clear is used only when the stream is idle or is being discarded.

**Simultaneous events**
- clear wins over an input handshake in the same cycle; that beat is discarded.
- A wrap at bin L-1 in the last frame (mode 0) resets frame to 0 on the same edge.

## Test plan
- Mode 0, L=4, N=4, input real=i+1 and imag=-(i+1) for bin i in every frame → 4 output beats only after frame 3: {-1,1}, {-2,2}, {-3,3}, {-4,4}; tlast on the 4th beat; no beats during frames 0-2.
- Mode 0, L=2, N=2, samples 3 then 4 into bin 0 → output floor(7/2)=3; samples -3 then -4 → -4.
- Mode 1, k=2, constant input 100 → first frame outputs 100; output stays 100. Then a step to 0 gives outputs 75, 56, 42 in successive frames.
- Random M_AXIS_tready (50%) with continuous S_AXIS_tvalid → output identical to the full-throughput run; tdata stable while stalled; no beats lost or duplicated.
- S_AXIS_tlast asserted on bin 2 with L=4 → sync_error rises the cycle after that handshake and stays high until clear.
- Change log_length mid-run without clear → no effect. Assert clear → next beat starts at bin 0, frame 0 with the new L, and M_AXIS_tvalid=0 one cycle after clear.

Source files
------------

// File: rtl/axis_frame_averager.sv
// axis_frame_averager
//   Accumulates complex per-bin samples ({imag, real}, two's complement)
//   over repeated frames in an internal memory. It has two modes:
//     mode 0 : block average over N = 2^log_count frames, one output frame per N
//     mode 1 : exponential average with shift k = log_count, output every frame
//   The pipeline has two stages: accept/read, then compute/write-back/output register.
//
// Ports
//   aclk, aresetn         clock, synchronous active-low reset
//   clear                 synchronous soft restart; latches mode/log_length/log_count
//   mode                  0 = block average, 1 = exponential average
//   log_length            frame length L = 2^log_length (clamped to 1..MAX_LOG_LENGTH)
//   log_count             N = 2^log_count or shift k (clamped to MAX_LOG_COUNT)
//   S_AXIS_*              input stream {imag, real}, tlast marks bin L-1
//   M_AXIS_*              averaged output stream, tlast on bin L-1
//   sync_error            sticky: S_AXIS_tlast disagreed with the bin position
module axis_frame_averager #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_LOG_LENGTH = 10,
  parameter int MAX_LOG_COUNT  = 8,
  parameter int ACC_WIDTH      = DATA_WIDTH + MAX_LOG_COUNT
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 clear,
  input  logic                                 mode,
  input  logic [$clog2(MAX_LOG_LENGTH+1)-1:0]  log_length,
  input  logic [$clog2(MAX_LOG_COUNT+1)-1:0]   log_count,
  input  logic [2*DATA_WIDTH-1:0]              S_AXIS_tdata,
  input  logic                                 S_AXIS_tvalid,
  output logic                                 S_AXIS_tready,
  input  logic                                 S_AXIS_tlast,
  output logic [2*DATA_WIDTH-1:0]              M_AXIS_tdata,
  output logic                                 M_AXIS_tvalid,
  input  logic                                 M_AXIS_tready,
  output logic                                 M_AXIS_tlast,
  output logic                                 sync_error
);

  localparam int LL_W  = $clog2(MAX_LOG_LENGTH+1);
  localparam int LC_W  = $clog2(MAX_LOG_COUNT+1);
  localparam int BIN_W = MAX_LOG_LENGTH;
  localparam int FRM_W = MAX_LOG_COUNT;
  localparam int DEPTH = 1 << MAX_LOG_LENGTH;

  // Frame length is at least 2 so that a bin's write-back always lands
  // before that bin is read again (no forwarding path needed).
  function automatic logic [LL_W-1:0] clamp_len(input logic [LL_W-1:0] v);
    logic [LL_W-1:0] r;
    if (v == '0)                           r = LL_W'(1);
    else if (v > LL_W'(MAX_LOG_LENGTH))    r = LL_W'(MAX_LOG_LENGTH);
    else                                   r = v;
    return r;
  endfunction

  function automatic logic [LC_W-1:0] clamp_cnt(input logic [LC_W-1:0] v);
    logic [LC_W-1:0] r;
    if (v > LC_W'(MAX_LOG_COUNT)) r = LC_W'(MAX_LOG_COUNT);
    else                          r = v;
    return r;
  endfunction

  // One component of the averaging step. Returns {output sample, new accumulator}.
  function automatic logic [DATA_WIDTH+ACC_WIDTH-1:0] avg_step(
    input logic                        exp_mode,
    input logic                        first,
    input logic                        init,
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] s,
    input logic [LC_W-1:0]             k
  );
    logic signed [ACC_WIDTH-1:0] nxt;
    logic signed [ACC_WIDTH-1:0] res;
    if (!exp_mode) begin
      nxt = first ? s : a + s;
      res = nxt >>> k;
    end else if (init) begin
      nxt = s <<< k;
      res = s;
    end else begin
      nxt = a - (a >>> k) + s;
      res = nxt >>> k;
    end
    return {res[DATA_WIDTH-1:0], nxt};
  endfunction

  logic                          cfg_mode;
  logic [LL_W-1:0]               cfg_len;
  logic [LC_W-1:0]               cfg_cnt;
  logic                          ready_en;
  logic [BIN_W-1:0]              bin;
  logic [FRM_W-1:0]              frame;
  logic                          init;

  logic                          s1_valid;
  logic                          s1_first;
  logic                          s1_out;
  logic                          s1_last;
  logic                          s1_init;
  logic [2*DATA_WIDTH-1:0]       s1_data;
  logic [BIN_W-1:0]              s1_bin;

  logic [2*ACC_WIDTH-1:0]        mem [DEPTH];
  logic [2*ACC_WIDTH-1:0]        rd_data;

  logic                          m_valid;
  logic                          m_last;
  logic [2*DATA_WIDTH-1:0]       m_data;
  logic                          sync_err;

  logic                          adv;
  logic                          accept;
  logic                          wr_en;
  logic                          bin_at_end;
  logic                          frame_at_end;
  logic [BIN_W-1:0]              bin_max;
  logic [FRM_W-1:0]              frame_max;
  logic signed [ACC_WIDTH-1:0]   a_re;
  logic signed [ACC_WIDTH-1:0]   a_im;
  logic signed [ACC_WIDTH-1:0]   s_re;
  logic signed [ACC_WIDTH-1:0]   s_im;
  logic [DATA_WIDTH+ACC_WIDTH-1:0] step_re;
  logic [DATA_WIDTH+ACC_WIDTH-1:0] step_im;
  logic [2*ACC_WIDTH-1:0]        wr_data;
  logic [2*DATA_WIDTH-1:0]       out_data;

  // The whole pipeline moves only when the output register can take a beat.
  assign adv           = !m_valid || M_AXIS_tready;
  assign S_AXIS_tready = ready_en && adv;
  assign accept        = S_AXIS_tvalid && S_AXIS_tready && !clear;
  assign wr_en         = adv && s1_valid && !clear;

  // Inverting an all-ones word shifted left by n gives n low ones, i.e. 2^n-1.
  assign bin_max      = ~({BIN_W{1'b1}} << cfg_len);
  assign frame_max    = ~({FRM_W{1'b1}} << cfg_cnt);
  assign bin_at_end   = (bin == bin_max);
  assign frame_at_end = (frame == frame_max);

  assign M_AXIS_tdata  = m_data;
  assign M_AXIS_tvalid = m_valid;
  assign M_AXIS_tlast  = m_last;
  assign sync_error    = sync_err;

  // Stage-2 arithmetic on the stored accumulator and the registered sample.
  always_comb begin
    a_re     = rd_data[ACC_WIDTH-1:0];
    a_im     = rd_data[2*ACC_WIDTH-1:ACC_WIDTH];
    s_re     = ACC_WIDTH'($signed(s1_data[DATA_WIDTH-1:0]));
    s_im     = ACC_WIDTH'($signed(s1_data[2*DATA_WIDTH-1:DATA_WIDTH]));
    step_re  = avg_step(cfg_mode, s1_first, s1_init, a_re, s_re, cfg_cnt);
    step_im  = avg_step(cfg_mode, s1_first, s1_init, a_im, s_im, cfg_cnt);
    wr_data  = {step_im[ACC_WIDTH-1:0], step_re[ACC_WIDTH-1:0]};
    out_data = {step_im[DATA_WIDTH+ACC_WIDTH-1:ACC_WIDTH],
                step_re[DATA_WIDTH+ACC_WIDTH-1:ACC_WIDTH]};
  end

  // Accumulator memory: read-first, read enabled by the accept strobe so the
  // read data holds through an output stall; contents are never reset.
  always_ff @(posedge aclk) begin
    if (accept) rd_data <= mem[bin];
    if (wr_en)  mem[s1_bin] <= wr_data;
  end

  // Configuration, counters, frame check, stage-1 and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear) begin
      cfg_mode <= mode;
      cfg_len  <= clamp_len(log_length);
      cfg_cnt  <= clamp_cnt(log_count);
      ready_en <= aresetn;  // low through reset, high straight after a clear
      bin      <= '0;
      frame    <= '0;
      init     <= 1'b1;
      s1_valid <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        bin <= bin_at_end ? '0 : bin + BIN_W'(1);
        if (bin_at_end) begin
          frame <= frame_at_end ? '0 : frame + FRM_W'(1);
          init  <= 1'b0;
        end
        if (S_AXIS_tlast != bin_at_end) sync_err <= 1'b1;
        s1_valid <= 1'b1;
        s1_data  <= S_AXIS_tdata;
        s1_bin   <= bin;
        s1_first <= (frame == '0);
        s1_out   <= cfg_mode || frame_at_end;
        s1_last  <= bin_at_end;
        s1_init  <= init;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
      if (adv) begin
        m_valid <= s1_valid && s1_out;
        if (s1_valid && s1_out) begin
          m_data <= out_data;
          m_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_averager.sv
module tb_axis_frame_averager;

  logic        aclk = 1'b0;
  logic        aresetn, clear, mode;
  logic [3:0]  log_length, log_count;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast;
  logic        sync_error;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int stall_bad = 0;

  logic [31:0] st_data[$];
  logic        st_last[$];
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  always #5 aclk = ~aclk;

  axis_frame_averager dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear), .mode(mode),
    .log_length(log_length), .log_count(log_count),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .S_AXIS_tlast(s_tlast),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .M_AXIS_tlast(m_tlast), .sync_error(sync_error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model helpers ----------------
  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int re_of(input int idx);
    logic [15:0] v;
    v = st_data[idx][15:0];
    return int'($signed(v));
  endfunction

  function automatic int im_of(input int idx);
    logic [15:0] v;
    v = st_data[idx][31:16];
    return int'($signed(v));
  endfunction

  function automatic logic [32:0] pack(input logic last, input int im, input int re);
    logic [15:0] i16, r16;
    i16 = im[15:0];
    r16 = re[15:0];
    return {last, i16, r16};
  endfunction

  task automatic gen_frames(input int len, input int nframes);
    st_data.delete(); st_last.delete();
    for (int f = 0; f < nframes; f++)
      for (int b = 0; b < len; b++) begin
        st_data.push_back($urandom);
        st_last.push_back(b == len - 1);
      end
  endtask

  // Block average: each complete group of n frames yields floor(mean) per bin.
  task automatic model_block(input int len, input int n);
    int nfr, sr, si, idx;
    exp_q.delete();
    nfr = st_data.size() / len;
    for (int g = 0; (g + 1) * n <= nfr; g++)
      for (int b = 0; b < len; b++) begin
        sr = 0; si = 0;
        for (int f = 0; f < n; f++) begin
          idx = (g * n + f) * len + b;
          sr += re_of(idx);
          si += im_of(idx);
        end
        exp_q.push_back(pack(b == len - 1, floordiv(si, n), floordiv(sr, n)));
      end
  endtask

  // Exponential average with scaled accumulator acc ~ avg * 2^k.
  task automatic model_exp(input int len, input int k);
    int ar[], ai[];
    int d, nfr, idx;
    ar = new[len]; ai = new[len];
    d = 1 << k;
    nfr = st_data.size() / len;
    exp_q.delete();
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < len; b++) begin
        idx = f * len + b;
        if (f == 0) begin
          ar[b] = re_of(idx) * d;
          ai[b] = im_of(idx) * d;
          exp_q.push_back(pack(b == len - 1, im_of(idx), re_of(idx)));
        end else begin
          ar[b] = ar[b] - floordiv(ar[b], d) + re_of(idx);
          ai[b] = ai[b] - floordiv(ai[b], d) + im_of(idx);
          exp_q.push_back(pack(b == len - 1, floordiv(ai[b], d), floordiv(ar[b], d)));
        end
      end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_cfg(input logic m, input logic [3:0] ll, input logic [3:0] lc);
    @(negedge aclk);
    mode = m; log_length = ll; log_count = lc; clear = 1'b1; s_tvalid = 1'b0;
    @(negedge aclk);
    clear = 1'b0;
    got_q.delete();
    stall_bad = 0;
  endtask

  // Streams st_data with continuous tvalid, M tready high with pct% chance,
  // collects output beats into got_q and counts stall-rule violations.
  task automatic run_stream(input int pct);
    int idx, guard, drain;
    logic prev_stall;
    logic [32:0] held;
    idx = 0; guard = 0; drain = 0; prev_stall = 1'b0; held = '0;
    while ((idx < st_data.size() || drain < 8) && guard < 20000) begin
      @(negedge aclk);
      guard++;
      if (idx < st_data.size()) begin
        s_tvalid = 1'b1; s_tdata = st_data[idx]; s_tlast = st_last[idx];
        m_tready = ($urandom_range(99) < pct);
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        drain++;
      end
      #1;
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== held)) stall_bad++;
      prev_stall = m_tvalid && !m_tready;
      held = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) got_q.push_back(held);
      if (s_tvalid && s_tready) idx++;
    end
    s_tvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0; clear = 1'b0; mode = 1'b0; log_length = 4'd2; log_count = 4'd2;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(negedge aclk);
    check_cnt++; if (s_tready !== 1'b0) $display("FAIL rst_s_tready: got %b expected 0", s_tready); else pass_cnt++;
    check_cnt++; if (m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); else pass_cnt++;
    check_cnt++; if (m_tdata !== 32'h0) $display("FAIL rst_m_tdata: got %h expected 0", m_tdata); else pass_cnt++;
    check_cnt++; if (m_tlast !== 1'b0) $display("FAIL rst_m_tlast: got %b expected 0", m_tlast); else pass_cnt++;
    check_cnt++; if (sync_error !== 1'b0) $display("FAIL rst_sync: got %b expected 0", sync_error); else pass_cnt++;
    aresetn = 1'b1;
    @(negedge aclk);
    check_cnt++; if (s_tready !== 1'b1) $display("FAIL post_rst_s_tready: got %b expected 1", s_tready); else pass_cnt++;
    check_cnt++; if (m_tvalid !== 1'b0) $display("FAIL post_rst_m_tvalid: got %b expected 0", m_tvalid); else pass_cnt++;
  endtask

  task automatic test_block_plan();
    logic [15:0] r16, i16;
    start_cfg(1'b0, 4'd2, 4'd2);
    st_data.delete(); st_last.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) begin
        r16 = 16'(i + 1); i16 = 16'(-(i + 1));
        st_data.push_back({i16, r16}); st_last.push_back(i == 3);
      end
    run_stream(100);
    check_cnt++; if (got_q.size() != 0) $display("FAIL plan_no_early: got %0d beats expected 0", got_q.size()); else pass_cnt++;
    st_data.delete(); st_last.delete();
    for (int i = 0; i < 4; i++) begin
      r16 = 16'(i + 1); i16 = 16'(-(i + 1));
      st_data.push_back({i16, r16}); st_last.push_back(i == 3);
    end
    run_stream(100);
    check_cnt++; if (got_q.size() != 4) $display("FAIL plan_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      r16 = 16'(i + 1); i16 = 16'(-(i + 1));
      check_cnt++;
      if (got_q[i] !== {i == 3, i16, r16}) $display("FAIL plan_beat%0d: got %h expected %h", i, got_q[i], {i == 3, i16, r16});
      else pass_cnt++;
    end
    check_cnt++; if (sync_error !== 1'b0) $display("FAIL plan_sync: got %b expected 0", sync_error); else pass_cnt++;
  endtask

  task automatic test_floor();
    start_cfg(1'b0, 4'd1, 4'd1);
    st_data = '{ {16'sd3, 16'sd3}, {-16'sd3, -16'sd3}, {16'sd4, 16'sd4}, {-16'sd4, -16'sd4} };
    st_last = '{ 1'b0, 1'b1, 1'b0, 1'b1 };
    run_stream(100);
    check_cnt++; if (got_q.size() != 2) $display("FAIL floor_count: got %0d expected 2", got_q.size()); else pass_cnt++;
    if (got_q.size() == 2) begin
      check_cnt++; if (got_q[0] !== {1'b0, 16'sd3, 16'sd3}) $display("FAIL floor_pos: got %h expected %h", got_q[0], {1'b0, 16'sd3, 16'sd3}); else pass_cnt++;
      check_cnt++; if (got_q[1] !== {1'b1, -16'sd4, -16'sd4}) $display("FAIL floor_neg: got %h expected %h", got_q[1], {1'b1, -16'sd4, -16'sd4}); else pass_cnt++;
    end
  endtask

  task automatic test_exp_step();
    int vals[6] = '{100, 100, 100, 75, 56, 42};
    logic [15:0] v;
    start_cfg(1'b1, 4'd1, 4'd2);
    st_data.delete(); st_last.delete();
    for (int f = 0; f < 6; f++)
      for (int b = 0; b < 2; b++) begin
        st_data.push_back((f < 3) ? {16'd100, 16'd100} : 32'd0);
        st_last.push_back(b == 1);
      end
    run_stream(100);
    check_cnt++; if (got_q.size() != 12) $display("FAIL exp_count: got %0d expected 12", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      v = vals[i / 2][15:0];
      check_cnt++;
      if (got_q[i] !== {(i % 2) == 1, v, v}) $display("FAIL exp_step%0d: got %h expected %h", i, got_q[i], {(i % 2) == 1, v, v});
      else pass_cnt++;
    end
  endtask

  task automatic test_random_block();
    int ll, lc, len, n;
    logic [32:0] first_run[$];
    for (int r = 0; r < 3; r++) begin
      ll = (r == 2) ? 1 : $urandom_range(1, 4);
      lc = (r == 2) ? 15 : $urandom_range(0, 3);
      len = 1 << ll;
      n = 1 << ((lc > 8) ? 8 : lc);
      gen_frames(len, 2 * n + 1);
      model_block(len, n);
      start_cfg(1'b0, 4'(ll), 4'(lc));
      run_stream(100);
      first_run = got_q;
      check_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL blk%0d_count: got %0d expected %0d", r, got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        check_cnt++;
        if (got_q[i] !== exp_q[i]) $display("FAIL blk%0d_beat%0d: got %h expected %h", r, i, got_q[i], exp_q[i]);
        else pass_cnt++;
      end
      start_cfg(1'b0, 4'(ll), 4'(lc));
      run_stream(50);
      check_cnt++; if (got_q.size() != first_run.size()) $display("FAIL blk%0d_stall_count: got %0d expected %0d", r, got_q.size(), first_run.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < first_run.size(); i++) begin
        check_cnt++;
        if (got_q[i] !== first_run[i]) $display("FAIL blk%0d_stall_beat%0d: got %h expected %h", r, i, got_q[i], first_run[i]);
        else pass_cnt++;
      end
      check_cnt++; if (stall_bad != 0) $display("FAIL blk%0d_stable: got %0d violations expected 0", r, stall_bad); else pass_cnt++;
      check_cnt++; if (sync_error !== 1'b0) $display("FAIL blk%0d_sync: got %b expected 0", r, sync_error); else pass_cnt++;
    end
  endtask

  task automatic test_random_exp();
    int ll, k, len;
    for (int r = 0; r < 3; r++) begin
      ll = $urandom_range(1, 3);
      k = (r == 0) ? 8 : $urandom_range(0, 8);
      len = 1 << ll;
      gen_frames(len, 6);
      model_exp(len, k);
      start_cfg(1'b1, 4'(ll), 4'(k));
      run_stream(50);
      check_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL expr%0d_count: got %0d expected %0d", r, got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        check_cnt++;
        if (got_q[i] !== exp_q[i]) $display("FAIL expr%0d_beat%0d: got %h expected %h", r, i, got_q[i], exp_q[i]);
        else pass_cnt++;
      end
      check_cnt++; if (stall_bad != 0) $display("FAIL expr%0d_stable: got %0d violations expected 0", r, stall_bad); else pass_cnt++;
    end
  endtask

  task automatic test_sync_error();
    // The beat offered during the clear cycle must be discarded, otherwise
    // the bin count is shifted and the bad tlast below lands on bin 3.
    @(negedge aclk);
    mode = 1'b0; log_length = 4'd2; log_count = 4'd0; clear = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 32'h1234_5678; s_tlast = 1'b0;
    @(negedge aclk);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge aclk);
      if (i == 3) begin
        check_cnt++; if (sync_error !== 1'b1) $display("FAIL sync_rise: got %b expected 1", sync_error); else pass_cnt++;
      end else if (i < 3) begin
        check_cnt++; if (sync_error !== 1'b0) $display("FAIL sync_low%0d: got %b expected 0", i, sync_error); else pass_cnt++;
      end
      s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = (i == 2);
    end
    @(negedge aclk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge aclk);
    check_cnt++; if (sync_error !== 1'b1) $display("FAIL sync_sticky: got %b expected 1", sync_error); else pass_cnt++;
    start_cfg(1'b0, 4'd2, 4'd0);
    check_cnt++; if (sync_error !== 1'b0) $display("FAIL sync_clear: got %b expected 0", sync_error); else pass_cnt++;
  endtask

  task automatic test_reconfig();
    // Mode 1 with k=0 passes samples through unchanged, exposing the framing.
    start_cfg(1'b1, 4'd2, 4'd0);
    gen_frames(4, 1);
    run_stream(100);
    check_cnt++; if (got_q.size() != 4) $display("FAIL cfg_a_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== {i == 3, st_data[i]}) $display("FAIL cfg_a_beat%0d: got %h expected %h", i, got_q[i], {i == 3, st_data[i]});
      else pass_cnt++;
    end
    @(negedge aclk);
    log_length = 4'd1;
    got_q.delete();
    gen_frames(4, 1);
    run_stream(100);
    check_cnt++; if (got_q.size() != 4) $display("FAIL cfg_b_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== {i == 3, st_data[i]}) $display("FAIL cfg_b_beat%0d: got %h expected %h", i, got_q[i], {i == 3, st_data[i]});
      else pass_cnt++;
    end
    // Leave one output beat pending, then clear with log_length=0 (clamps to L=2).
    @(negedge aclk);
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'b0;
    @(negedge aclk);
    s_tvalid = 1'b0;
    @(negedge aclk);
    check_cnt++; if (m_tvalid !== 1'b1) $display("FAIL cfg_pending: got %b expected 1", m_tvalid); else pass_cnt++;
    log_length = 4'd0; clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
    check_cnt++; if (m_tvalid !== 1'b0) $display("FAIL cfg_clear_valid: got %b expected 0", m_tvalid); else pass_cnt++;
    check_cnt++; if (s_tready !== 1'b1) $display("FAIL cfg_clear_ready: got %b expected 1", s_tready); else pass_cnt++;
    got_q.delete();
    gen_frames(2, 2);
    run_stream(100);
    check_cnt++; if (got_q.size() != 4) $display("FAIL cfg_c_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== {(i % 2) == 1, st_data[i]}) $display("FAIL cfg_c_beat%0d: got %h expected %h", i, got_q[i], {(i % 2) == 1, st_data[i]});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_block_plan();
    test_floor();
    test_exp_step();
    test_random_block();
    test_random_exp();
    test_sync_error();
    test_reconfig();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
